// File: rtl/alien_formation_if.sv
// Bus between the alien formation and its neighbours: frame/bullet inputs in,
// alien RGB layer and hit reporting out.
interface alien_formation_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic               fsync;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic signed [11:0] bullet_x;
    logic signed [11:0] bullet_y;
    logic               bullet_active;
    logic [7:0]         pixel [0:2];
    logic               active;
    logic [N-1:0]       alive_mask;
    logic               alien_hit;
    logic [IW-1:0]      hit_index;
    logic               bullet_consume;
    logic               all_dead;

    modport master (
        output fsync, hpos, vpos, bullet_x, bullet_y, bullet_active,
        input  pixel, active, alive_mask, alien_hit, hit_index, bullet_consume, all_dead
    );

    modport slave (
        input  fsync, hpos, vpos, bullet_x, bullet_y, bullet_active,
        output pixel, active, alive_mask, alien_hit, hit_index, bullet_consume, all_dead
    );
endinterface

// File: rtl/alien_formation.sv
// ROWS x COLS alien grid: per-frame bullet hit scan, marching with
// edge drop/reverse, one-slot explosion, and a registered RGB layer.
module alien_formation #(
    parameter int COLS            = 4,
    parameter int ROWS            = 2,
    parameter int ALIEN_W         = 20,
    parameter int ALIEN_H         = 20,
    parameter int GAP_X           = 12,
    parameter int GAP_Y           = 12,
    parameter int START_X         = 100,
    parameter int START_Y         = 100,
    parameter int STEP_X          = 2,
    parameter int DROP_Y          = 8,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 1279,
    parameter int FRAMES_PER_STEP = 4,
    parameter int EXPLODE_FRAMES  = 8
) (
    input  logic              pixel_clk,
    input  logic              rst,
    alien_formation_if.slave  bus
);
    localparam int N   = ROWS * COLS;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int FCW = $clog2(FRAMES_PER_STEP + 1);
    localparam int ECW = $clog2(EXPLODE_FRAMES + 1);
    localparam logic signed [13:0] XMIN14    = 14'(X_MIN);
    localparam logic signed [13:0] XMAX14    = 14'(X_MAX);
    localparam logic signed [13:0] RIGHT_OFF = 14'(COLS * (ALIEN_W + GAP_X) - GAP_X - 1);
    localparam logic signed [13:0] STEP14    = 14'(STEP_X);

    typedef enum logic [1:0] {IDLE, SCAN, MOVE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               fsync_q, evt_q;
    logic signed [11:0] bx_q, bx_d, by_q, by_d;
    logic [N-1:0]       alive_q, alive_d;
    logic signed [11:0] form_x_q, form_x_d, form_y_q, form_y_d;
    logic               dir_q, dir_d;
    logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [IW-1:0]      exp_idx_q, exp_idx_d;
    logic [ECW-1:0]     exp_cnt_q, exp_cnt_d;
    logic               hit_q, hit_d;
    logic [IW-1:0]      hit_idx_q, hit_idx_d;
    logic               all_dead_q;
    logic [7:0]         pixel_q [0:2];
    logic               active_q;

    logic signed [12:0] box_x [N];
    logic signed [12:0] box_y [N];
    logic signed [13:0] next_x;
    logic               draw_live, draw_boom;

    function automatic logic in_box(input logic signed [12:0] px, input logic signed [12:0] py,
                                    input logic signed [12:0] x0, input logic signed [12:0] y0);
        return (px >= x0) && (px <= x0 + 13'(ALIEN_W - 1)) &&
               (py >= y0) && (py <= y0 + 13'(ALIEN_H - 1));
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            box_x[i] = 13'(form_x_q) + 13'((i % COLS) * (ALIEN_W + GAP_X));
            box_y[i] = 13'(form_y_q) + 13'((i / COLS) * (ALIEN_H + GAP_Y));
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bx_d        = bx_q;
        by_d        = by_q;
        alive_d     = alive_q;
        form_x_d    = form_x_q;
        form_y_d    = form_y_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;
        exp_idx_d   = exp_idx_q;
        exp_cnt_d   = exp_cnt_q;
        hit_d       = 1'b0;
        hit_idx_d   = hit_idx_q;
        next_x      = dir_q ? (14'(form_x_q) - STEP14) : (14'(form_x_q) + STEP14);

        case (state_q)
            IDLE: begin
                if (evt_q) begin
                    bx_d    = bus.bullet_x;
                    by_d    = bus.bullet_y;
                    idx_d   = '0;
                    state_d = bus.bullet_active ? SCAN : MOVE;
                end
            end
            SCAN: begin
                if (alive_q[idx_q] && in_box(13'(bx_q), 13'(by_q), box_x[idx_q], box_y[idx_q])) begin
                    alive_d[idx_q] = 1'b0;
                    hit_d          = 1'b1;
                    hit_idx_d      = idx_q;
                    exp_idx_d      = idx_q;
                    exp_cnt_d      = ECW'(EXPLODE_FRAMES);
                    state_d        = MOVE;
                end else if (idx_q == IW'(N - 1)) begin
                    state_d = MOVE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            MOVE: begin
                if (exp_cnt_q != '0) exp_cnt_d = exp_cnt_q - ECW'(1);
                if (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1)) begin
                    frame_cnt_d = '0;
                    // Edge test covers the whole grid, dead columns included.
                    if ((next_x < XMIN14) || (next_x + RIGHT_OFF > XMAX14)) begin
                        form_y_d = form_y_q + 12'(DROP_Y);
                        dir_d    = ~dir_q;
                    end else begin
                        form_x_d = next_x[11:0];
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        draw_live = 1'b0;
        draw_boom = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_box(13'(bus.hpos), 13'(bus.vpos), box_x[i], box_y[i])) begin
                if (alive_q[i]) draw_live = 1'b1;
                else if ((exp_cnt_q != '0) && (exp_idx_q == IW'(i))) draw_boom = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            fsync_q     <= 1'b0;
            evt_q       <= 1'b0;
            bx_q        <= '0;
            by_q        <= '0;
            alive_q     <= '1;
            form_x_q    <= 12'(START_X);
            form_y_q    <= 12'(START_Y);
            dir_q       <= 1'b0;
            frame_cnt_q <= '0;
            exp_idx_q   <= '0;
            exp_cnt_q   <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            all_dead_q  <= 1'b0;
            active_q    <= 1'b0;
            for (int c = 0; c < 3; c++) pixel_q[c] <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fsync_q     <= bus.fsync;
            evt_q       <= bus.fsync & ~fsync_q;
            bx_q        <= bx_d;
            by_q        <= by_d;
            alive_q     <= alive_d;
            form_x_q    <= form_x_d;
            form_y_q    <= form_y_d;
            dir_q       <= dir_d;
            frame_cnt_q <= frame_cnt_d;
            exp_idx_q   <= exp_idx_d;
            exp_cnt_q   <= exp_cnt_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            all_dead_q  <= (alive_q == '0);
            active_q    <= draw_live | draw_boom;
            pixel_q[0]  <= draw_boom ? 8'd255 : 8'd0;
            pixel_q[1]  <= draw_live ? 8'd255 : (draw_boom ? 8'd128 : 8'd0);
            pixel_q[2]  <= 8'd0;
        end
    end

    assign bus.pixel[0]       = pixel_q[0];
    assign bus.pixel[1]       = pixel_q[1];
    assign bus.pixel[2]       = pixel_q[2];
    assign bus.active         = active_q;
    assign bus.alive_mask     = alive_q;
    assign bus.alien_hit      = hit_q;
    assign bus.bullet_consume = hit_q;
    assign bus.hit_index      = hit_idx_q;
    assign bus.all_dead       = all_dead_q;
endmodule

// File: doc/alien_formation.md
Name: alien_formation

Overview:
Parametrised successor to the single-alien block. It manages a ROWS x COLS grid of aliens with per-alien alive state and a sequential per-frame bullet hit scan. It also handles marching movement with edge-drop-and-reverse and a one-slot explosion animation. It sits between the bullet/player logic and the pixel mux, driving the alien RGB layer for the current hpos/vpos.

Parameters:
COLS, 4, aliens per row
ROWS, 2, number of rows; N = ROWS*COLS
ALIEN_W, 20, alien box width (px)
ALIEN_H, 20, alien box height (px)
GAP_X, 12, horizontal gap between aliens
GAP_Y, 12, vertical gap between rows
START_X, 100, formation origin x at reset
START_Y, 100, formation origin y at reset
STEP_X, 2, px per march step
DROP_Y, 8, px dropped on edge reversal
X_MIN, 0, leftmost allowed formation pixel
X_MAX, 1279, rightmost allowed formation pixel
FRAMES_PER_STEP, 4, frames between march steps (>=1)
EXPLODE_FRAMES, 8, frames an explosion is drawn

Ports:
pixel_clk  in  1  pixel clock; the only clock
rst  in  1  reset, synchronous, active-high
fsync  in  1  frame sync
hpos  in  12 signed  current pixel x
vpos  in  12 signed  current pixel y
bullet_x  in  12 signed  bullet x
bullet_y  in  12 signed  bullet y
bullet_active  in  1  bullet in flight
pixel  out  3x8 (unpacked [0:2])  RGB of alien layer
active  out  1  alien layer opaque at (hpos,vpos)
alive_mask  out  N  bit i = alien i alive; index = row*COLS+col
alien_hit  out  1  one-cycle hit pulse
hit_index  out  $clog2(N)  index of alien hit, valid with alien_hit
bullet_consume  out  1  one-cycle pulse coincident with alien_hit
all_dead  out  1  alive_mask == 0

Behaviour:
- Reset (sync, rst=1 at posedge): alive_mask all ones; form_x=START_X, form_y=START_Y; dir=right; frame_cnt=0; no explosion; FSM=IDLE. Outputs pixel=0, active=0, alien_hit=0, bullet_consume=0, hit_index=0. all_dead=0. rst during SCAN/MOVE aborts and fully restores reset state.
- Frame event: fsync=1 this cycle and 0 the previous cycle (edge detected; a held fsync counts once).
- Alien i box: x0 = form_x + col*(ALIEN_W+GAP_X), y0 = form_y + row*(ALIEN_H+GAP_Y). Hit/draw is inclusive on [x0, x0+ALIEN_W-1] x [y0, y0+ALIEN_H-1]. All compares are signed 12-bit; negative coordinates never match a box at non-negative positions.
- FSM:
  - IDLE: on a frame event, latch bullet_x, bullet_y and bullet_active. If latched active, go to SCAN with idx=0; otherwise go to MOVE.
  - SCAN: one alien per cycle, idx 0..N-1. If alien idx is alive and the latched bullet is inside its box: clear alive bit, pulse alien_hit and bullet_consume, set hit_index=idx, load the explosion slot (idx, EXPLODE_FRAMES), then go to MOVE. Only the lowest-index hit is taken; at most one kill per frame. After idx=N-1 with no hit, go to MOVE.
  - MOVE (1 cycle): decrement the explosion counter if nonzero; the explosion clears at 0. frame_cnt++. If frame_cnt reaches FRAMES_PER_STEP: reset frame_cnt to 0 and step. Step: next_x = form_x ± STEP_X. If next_x < X_MIN or next_x + COLS*(ALIEN_W+GAP_X) - GAP_X - 1 > X_MAX, keep form_x, add DROP_Y to form_y and flip dir; otherwise form_x = next_x. Edge test uses the full grid, including dead aliens. Then go to IDLE.
- Frame events arriving in SCAN or MOVE are ignored.
- Hit latency: alien_hit asserts 2+idx cycles after the fsync rising edge (registered detect, latch, scan).
- Render: pixel/active are registered with 1-cycle latency from hpos/vpos.
  - Live alien box: active=1, pixel={0,255,0}.
  - Exploding (dead) alien box: active=1, pixel={255,128,0}.
  - Otherwise: active=0, pixel={0,0,0}.
  - A new hit during an explosion replaces the slot.
- all_dead is registered and updates the cycle after the final alive bit clears.

Test Plan:
- Miss/gap (FRAMES_PER_STEP=1000): bullet (50,110), then (125,110), each with one fsync -> no alien_hit; alive_mask=8'hFF.
- Hit + latency: bullet (105,105), fsync -> alien_hit exactly 1 cycle, hit_index=0, alive_mask=8'hFE, pulse 2 cycles after fsync edge. Repeat same bullet -> no hit, mask unchanged.
- Edge/priority: bullet (151,119), which is alien 1's inclusive corner -> hit_index=1. Bullet (152,119) -> no hit. bullet_active=0 at (137,105) -> no hit.
- March (X_MAX=219, STEP_X=2, FRAMES_PER_STEP=1): frames 1,2 -> form_x 102, 104. Frame 3 -> form_x stays 104, form_y=108, dir=left. Frame 4 -> form_x=102.
- Render/explosion: after killing alien 0, pixel at (110,110) is {255,128,0} for 8 frames, then active=0. An alive alien pixel is {0,255,0} one cycle after hpos/vpos applied.
- Kill all 8 -> all_dead=1. Assert rst mid-SCAN -> mask 8'hFF, form (100,100), alien_hit=0 next cycle.
